// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: blanking values,
// digit count and the active-low hex segment table.
package seg_scan_driver_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] EN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry n (LSB first) is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };
endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Nibble to active-low seven-segment pattern, purely combinational.
module hex_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver. The displayed word is
// snapshotted once per frame so digits never tear mid-scan, and every digit
// slot opens with a short all-off gap to suppress ghosting.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 64,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [3:0]  en,
  output logic [6:0]  y,
  output logic        frame_done
);
  localparam logic [DIV_BITS-1:0] CNT_MAX   = '1;
  localparam logic [DIV_BITS-1:0] BLANK_CNT = DIV_BITS'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0]  LAST_DIG  = DIGIT_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0] cnt;
  logic [DIGIT_W-1:0]  digit;
  logic [15:0]         shadow;
  logic [6:0]          seg_pat;
  logic                slot_end;
  logic                lz_off;
  logic                blank;

  assign slot_end = (cnt == CNT_MAX);

  hex_to_seg u_hex (
    .nib (shadow[{digit, 2'b00} +: 4]),
    .seg (seg_pat)
  );

  // A leading digit is dark when it and everything above it are zero; digit 0 always shows.
  assign lz_off = LZ_BLANK && (digit != '0) && ((shadow >> {digit, 2'b00}) == 16'h0000);
  assign blank  = (cnt < BLANK_CNT) || lz_off;

  // Prescaler, digit index and frame snapshot; the word is captured on the 3 -> 0 wrap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      digit  <= '0;
      shadow <= 16'h0000;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        digit <= digit + 1'b1;
        if (digit == LAST_DIG) shadow <= value;
      end
    end
  end

  // Registered outputs, one clk behind the scan state so en and y switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en         <= EN_OFF;
      y          <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_end && (digit == LAST_DIG);
      if (blank) begin
        en <= EN_OFF;
        y  <= SEG_BLANK;
      end else begin
        en <= ~(4'b0001 << digit);
        y  <= seg_pat;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with a 4-cycle slot and 1-cycle blank gap.
// Two instances (leading-zero blanking off/on) share all inputs; a
// cycle-count based reference model predicts every output each cycle.
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  en, lz_en;
  logic [6:0]  y, lz_y;
  logic        frame_done, lz_frame_done;

  int checks   = 0;
  int failures = 0;

  // Model state: k = edges since reset release, msh = word on display.
  int          k      = 0;
  int          cyc    = 0;
  int          last_fd = -1;
  logic [15:0] msh    = 16'h0000;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_driver #(.DIV_BITS(2), .BLANK_CYCLES(1), .LZ_BLANK(1'b0)) u_dut (
    .clk(clk), .reset(reset), .value(value),
    .en(en), .y(y), .frame_done(frame_done)
  );

  seg_scan_driver #(.DIV_BITS(2), .BLANK_CYCLES(1), .LZ_BLANK(1'b1)) u_lz (
    .clk(clk), .reset(reset), .value(value),
    .en(lz_en), .y(lz_y), .frame_done(lz_frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Outputs after edge kk: they show slot position (kk-1) of a 16-cycle frame.
  function automatic void model_out(input int kk, input logic [15:0] sh, input bit lz,
                                    output logic [3:0] e, output logic [6:0] s);
    int p, c, d;
    p = kk - 1;
    c = p % 4;
    d = (p / 4) % 4;
    e = 4'hF;
    s = 7'h7F;
    if (kk > 0 && c >= 1 && !(lz && d > 0 && (sh >> (4 * d)) == 16'h0000)) begin
      e[d] = 1'b0;
      s    = SEG_REF[sh[4*d +: 4]];
    end
  endfunction

  task automatic tick();
    logic [15:0] vpre;
    logic [3:0]  e0, e1;
    logic [6:0]  s0, s1;
    logic        efd;
    vpre = value;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      k = 0; msh = 16'h0000; last_fd = -1;
      e0 = 4'hF; e1 = 4'hF; s0 = 7'h7F; s1 = 7'h7F; efd = 1'b0;
    end else begin
      k++;
      model_out(k, msh, 1'b0, e0, s0);
      model_out(k, msh, 1'b1, e1, s1);
      efd = (k % 16 == 0);
      if (k % 16 == 0) msh = vpre;
    end
    chk("en", en, e0);
    chk("y", y, s0);
    chk("frame_done", frame_done, efd);
    chk("lz_en", lz_en, e1);
    chk("lz_y", lz_y, s1);
    chk("lz_frame_done", lz_frame_done, efd);
    chk("one_anode", $countones(~en) <= 1, 1);
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("fd_period", cyc - last_fd, 16);
      last_fd = cyc;
    end
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 200 && k < target; i++) tick();
    chk("run_to_reached", k, target);
  endtask

  initial begin
    // 1. reset, then release with 1234; frame 0 shows 0000
    reset = 1'b1;
    value = 16'h1234;
    #2;
    chk("rst_en", en, 4'hF);
    chk("rst_y", y, 7'h7F);
    chk("rst_fd", frame_done, 1'b0);
    tick(); tick();
    chk("rst_hold_en", en, 4'hF);
    reset = 1'b0;
    run_to(2);
    chk("f0_en", en, 4'hE);
    chk("f0_y", y, 7'h40);
    run_to(16);
    chk("f0_done", frame_done, 1'b1);
    // 2. A5F8 sampled at the end of frame 1
    value = 16'hA5F8;
    run_to(18);
    chk("f1_y", y, 7'h19);
    run_to(33);
    chk("f2_gap_en", en, 4'hF);
    run_to(34);
    chk("f2_d0", {en, 1'b0, y}, {4'hE, 8'h00});
    run_to(38);
    chk("f2_d1", {en, 1'b0, y}, {4'hD, 8'h0E});
    run_to(42);
    chk("f2_d2", {en, 1'b0, y}, {4'hB, 8'h12});
    run_to(45);
    chk("f2_gap3_en", en, 4'hF);
    run_to(46);
    chk("f2_d3", {en, 1'b0, y}, {4'h7, 8'h08});
    // 3. 1111 shown in frame 4, changed to 2222 mid-frame
    value = 16'h1111;
    run_to(70);
    value = 16'h2222;
    run_to(74);
    chk("mid_keep_y", y, 7'h79);
    run_to(82);
    chk("next_y", y, 7'h24);
    // 4. leading-zero blanking with 0007 in frame 6
    value = 16'h0007;
    run_to(98);
    chk("lz_d0", {lz_en, 1'b0, lz_y}, {4'hE, 8'h78});
    run_to(102);
    chk("lz_d1_en", lz_en, 4'hF);
    run_to(106);
    chk("lz_d2_en", lz_en, 4'hF);
    run_to(110);
    chk("lz_d3_en", lz_en, 4'hF);
    chk("nolz_d3_y", y, 7'h40);
    // 5. async reset at cnt=2 of digit 2
    value = 16'h9999;
    run_to(122);
    chk("pre_rst_en", en, 4'hB);
    reset = 1'b1;
    #1;
    chk("async_en", en, 4'hF);
    chk("async_y", y, 7'h7F);
    chk("async_fd", frame_done, 1'b0);
    tick(); tick();
    reset = 1'b0;
    run_to(2);
    chk("restart_en", en, 4'hE);
    chk("restart_y", y, 7'h40);
    // 6. random words, model checked every cycle
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) value = 16'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
